// File: rtl/slow_clk_monitor.sv
// rtl/slow_clk_monitor.sv - slow clock edge ticks, half-period measurement and fault monitor
// Two identical channels (1Hz, 2Hz); status aggregated and registered at the top.

module slow_clk_chan #(
  parameter int HALF  = 40_000_000,
  parameter int TOL   = 1024,
  parameter int CNT_W = 26
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_in,
  input  logic             clear_fault,
  output logic             tick,
  output logic [CNT_W-1:0] meas,
  output logic [1:0]       code,
  output logic             in_lock,
  output logic             in_fault
);
  localparam logic [CNT_W-1:0] LIM = CNT_W'(HALF + TOL);
  localparam logic [CNT_W-1:0] LO  = CNT_W'(HALF - TOL);
  localparam logic [1:0] CODE_NONE    = 2'd0;
  localparam logic [1:0] CODE_TIMEOUT = 2'd1;
  localparam logic [1:0] CODE_SHORT   = 2'd2;

  typedef enum logic [1:0] {ST_WAIT, ST_ACQ, ST_LOCK, ST_FAULT} state_t;

  state_t           state, state_n;
  logic [1:0]       good, good_n;
  logic [1:0]       code_q, code_n;
  logic             sync_a, sync_q, hist_q;
  logic [CNT_W-1:0] cnt, m;
  logic             edge_det, timeout, short_p, meas_upd;

  assign edge_det = sync_q ^ hist_q;
  assign m        = (&cnt) ? cnt : cnt + CNT_W'(1);
  // Any count at or past the upper bound is a timeout, even if an edge lands on it.
  assign timeout  = cnt >= LIM;
  assign short_p  = m < LO;
  assign in_lock  = (state == ST_LOCK);
  assign in_fault = (state == ST_FAULT);

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_a <= 1'b0;
      sync_q <= 1'b0;
      hist_q <= 1'b0;
      tick   <= 1'b0;
    end else begin
      sync_a <= clk_in;
      sync_q <= sync_a;
      hist_q <= sync_q;
      tick   <= sync_q & ~hist_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || clear_fault || edge_det) begin
      cnt <= '0;
    end else if (!(&cnt)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_n  = state;
    good_n   = good;
    code_n   = code_q;
    meas_upd = 1'b0;
    case (state)
      ST_WAIT: begin
        if (timeout) begin
          state_n = ST_FAULT;
          code_n  = CODE_TIMEOUT;
        end else if (edge_det) begin
          state_n = ST_ACQ;
          good_n  = 2'd0;
        end
      end
      ST_ACQ, ST_LOCK: begin
        if (timeout) begin
          state_n = ST_FAULT;
          code_n  = CODE_TIMEOUT;
        end else if (edge_det) begin
          meas_upd = 1'b1;
          if (short_p) begin
            state_n = ST_FAULT;
            code_n  = CODE_SHORT;
          end else if (state == ST_ACQ) begin
            good_n = good + 2'd1;
            if (good == 2'd1) state_n = ST_LOCK;
          end
        end
      end
      default: begin
        if (edge_det) meas_upd = 1'b1;
      end
    endcase
    if (clear_fault) begin
      state_n  = ST_WAIT;
      good_n   = 2'd0;
      code_n   = CODE_NONE;
      meas_upd = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= ST_WAIT;
      good   <= 2'd0;
      code_q <= CODE_NONE;
      code   <= CODE_NONE;
      meas   <= '0;
    end else begin
      state  <= state_n;
      good   <= good_n;
      code_q <= code_n;
      code   <= code_q;
      if (meas_upd) meas <= m;
    end
  end
endmodule

module slow_clk_monitor #(
  parameter int HALF_1HZ = 40_000_000,
  parameter int HALF_2HZ = 20_000_000,
  parameter int TOL      = 1024,
  parameter int CNT_W    = 26
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_1Hz_in,
  input  logic             clk_2Hz_in,
  input  logic             clear_fault,
  output logic             tick_1Hz,
  output logic             tick_2Hz,
  output logic [CNT_W-1:0] meas_1Hz,
  output logic [CNT_W-1:0] meas_2Hz,
  output logic [1:0]       code_1Hz,
  output logic [1:0]       code_2Hz,
  output logic             fault,
  output logic             locked
);
  logic lock_1, lock_2, fault_1, fault_2;

  slow_clk_chan #(.HALF(HALF_1HZ), .TOL(TOL), .CNT_W(CNT_W)) u_ch_1hz (
    .clk         (clk),
    .reset       (reset),
    .clk_in      (clk_1Hz_in),
    .clear_fault (clear_fault),
    .tick        (tick_1Hz),
    .meas        (meas_1Hz),
    .code        (code_1Hz),
    .in_lock     (lock_1),
    .in_fault    (fault_1)
  );

  slow_clk_chan #(.HALF(HALF_2HZ), .TOL(TOL), .CNT_W(CNT_W)) u_ch_2hz (
    .clk         (clk),
    .reset       (reset),
    .clk_in      (clk_2Hz_in),
    .clear_fault (clear_fault),
    .tick        (tick_2Hz),
    .meas        (meas_2Hz),
    .code        (code_2Hz),
    .in_lock     (lock_2),
    .in_fault    (fault_2)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      locked <= 1'b0;
      fault  <= 1'b0;
    end else begin
      locked <= lock_1 & lock_2;
      fault  <= fault_1 | fault_2;
    end
  end
endmodule

// File: tb/tb_slow_clk_monitor.sv
// tb/tb_slow_clk_monitor.sv - directed bench for slow_clk_monitor
// Slot s = number of clk edges since reset release; inputs driven and outputs sampled 1 time unit after each edge.

module tb_slow_clk_monitor;
  logic       clk = 1'b0;
  logic       reset, clk_1Hz_in, clk_2Hz_in, clear_fault;
  logic       tick_1Hz, tick_2Hz, fault, locked;
  logic [7:0] meas_1Hz, meas_2Hz;
  logic [1:0] code_1Hz, code_2Hz;

  int s = 0, nx1 = 0, n1 = 0, n2 = 0;
  bit en1 = 0, en2 = 0;
  int ntot = 0, npass = 0, nfail = 0;

  always #5 clk = ~clk;

  slow_clk_monitor #(.HALF_1HZ(40), .HALF_2HZ(20), .TOL(2), .CNT_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .clk_1Hz_in  (clk_1Hz_in),
    .clk_2Hz_in  (clk_2Hz_in),
    .clear_fault (clear_fault),
    .tick_1Hz    (tick_1Hz),
    .tick_2Hz    (tick_2Hz),
    .meas_1Hz    (meas_1Hz),
    .meas_2Hz    (meas_2Hz),
    .code_1Hz    (code_1Hz),
    .code_2Hz    (code_2Hz),
    .fault       (fault),
    .locked      (locked)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d (slot %0d)", tag, obs, exp, s);
    end
  endtask

  // 2Hz toggles on multiples of 20; 1Hz toggles at nx1 then every 40 unless overridden.
  task automatic step();
    @(posedge clk);
    #1;
    s++;
    n1 += int'(tick_1Hz);
    n2 += int'(tick_2Hz);
    if (en2 && (s % 20 == 0)) clk_2Hz_in = ~clk_2Hz_in;
    if (en1 && (s == nx1)) begin
      clk_1Hz_in = ~clk_1Hz_in;
      nx1 = s + 40;
    end
  endtask

  task automatic run_to(input int t);
    while (s < t) step();
  endtask

  task automatic start_nominal();
    reset      = 1'b1;
    clk_1Hz_in = 1'b1;
    clk_2Hz_in = 1'b1;
    nx1 = 40;
    en1 = 1;
    en2 = 1;
    s  = 0;
    n1 = 0;
    n2 = 0;
  endtask

  function automatic logic [31:0] all_out();
    return 32'({tick_1Hz, tick_2Hz, meas_1Hz, meas_2Hz, code_1Hz, code_2Hz, fault, locked});
  endfunction

  initial begin
    reset = 1'b0; clk_1Hz_in = 1'b0; clk_2Hz_in = 1'b0; clear_fault = 1'b0;
    run_to(4);
    chk("reset_outputs", all_out(), 0);
    start_nominal();

    // Nominal start, simultaneous rising edges on both inputs
    run_to(2);   chk("tick_early", 32'({tick_1Hz, tick_2Hz}), 0);
    run_to(3);   chk("tick_both", 32'({tick_1Hz, tick_2Hz}), 3);
    run_to(4);   chk("tick_one_cycle", 32'({tick_1Hz, tick_2Hz}), 0);
    run_to(23);  chk("no_tick_on_fall", 32'(tick_2Hz), 0);
                 chk("meas_2hz_first", 32'(meas_2Hz), 20);
    run_to(43);  chk("meas_1hz_first", 32'(meas_1Hz), 40);
    run_to(83);  chk("locked_before", 32'(locked), 0);
    run_to(84);  chk("locked_after", 32'(locked), 1);
                 chk("codes_nominal", 32'({code_1Hz, code_2Hz, fault}), 0);
    run_to(200); chk("locked_stays", 32'(locked), 1);
                 chk("meas_nominal", 32'({meas_1Hz, meas_2Hz}), {16'd0, 8'd40, 8'd20});
                 chk("tick_count_1hz", 32'(n1), 3);
                 chk("tick_count_2hz", 32'(n2), 5);

    // Stuck 2Hz input
    en2 = 0;
    run_to(226); chk("stuck_code_pre", 32'(code_2Hz), 0);
                 chk("stuck_locked_pre", 32'(locked), 1);
    run_to(227); chk("stuck_code", 32'(code_2Hz), 1);
                 chk("stuck_fault", 32'(fault), 1);
                 chk("stuck_locked", 32'(locked), 0);
    run_to(230); en2 = 1;
    run_to(300); chk("stuck_sticky", 32'({code_2Hz, fault, locked}), 32'({2'd1, 1'b1, 1'b0}));
                 chk("stuck_other_ok", 32'(code_1Hz), 0);

    // Plain clear, both channels reacquire
    clear_fault = 1'b1;
    run_to(301); clear_fault = 1'b0;
    run_to(302); chk("clear_code", 32'({code_2Hz, fault}), 0);
    run_to(403); chk("relock_before", 32'(locked), 0);
    run_to(404); chk("relock_after", 32'(locked), 1);

    // 38-cycle half-period in range, then 30-cycle short
    run_to(400); nx1 = 438;
    run_to(438); nx1 = 468;
    run_to(441); chk("meas_38", 32'(meas_1Hz), 38);
                 chk("no_fault_38", 32'({code_1Hz, fault, locked}), 1);
    run_to(471); chk("meas_30", 32'(meas_1Hz), 30);
                 chk("short_code_pre", 32'(code_1Hz), 0);
    run_to(472); chk("short_code", 32'(code_1Hz), 2);
                 chk("short_status", 32'({fault, locked}), 2);

    // clear_fault in the same cycle as a 2Hz timeout
    run_to(480); en2 = 0;
    run_to(505); clear_fault = 1'b1;
    run_to(506); clear_fault = 1'b0; en2 = 1;
                 chk("clr_viol_pre", 32'({code_1Hz, fault}), 32'({2'd2, 1'b1}));
    run_to(507); chk("clr_viol_code", 32'({code_1Hz, code_2Hz}), 0);
                 chk("clr_viol_fault", 32'(fault), 0);
    run_to(591); chk("relock2_before", 32'(locked), 0);
    run_to(592); chk("relock2_after", 32'(locked), 1);
                 chk("relock2_meas", 32'({meas_1Hz, meas_2Hz}), {16'd0, 8'd40, 8'd20});

    // Reset while a 1Hz tick is one cycle from the output
    run_to(630); chk("pre_reset_locked", 32'(locked), 1);
    reset = 1'b0; en1 = 0; en2 = 0;
    run_to(631); chk("mid_reset_outputs", all_out(), 0);
    clk_1Hz_in = 1'b0; clk_2Hz_in = 1'b0;
    run_to(635); chk("mid_reset_hold", all_out(), 0);
    start_nominal();
    run_to(3);   chk("rst_tick_both", 32'({tick_1Hz, tick_2Hz}), 3);
    run_to(83);  chk("rst_locked_before", 32'(locked), 0);
    run_to(84);  chk("rst_locked_after", 32'(locked), 1);
                 chk("rst_meas", 32'({meas_1Hz, meas_2Hz}), {16'd0, 8'd40, 8'd20});

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
